// File: rtl/mskaes_rnd_pkg.sv
// Shared definitions for the masked-AES randomness feeder.
// Contents: FSM state encoding, xorshift128 shift amounts, seed words per lane,
// and the xorshift128 output-word update function.
package mskaes_rnd_pkg;

   typedef enum logic [1:0] {
      StSeed      = 2'd0,
      StWarm      = 2'd1,
      StReady     = 2'd2,
      StExhausted = 2'd3
   } rnd_state_e;

   localparam int unsigned XsShiftA         = 11;
   localparam int unsigned XsShiftB         = 19;
   localparam int unsigned XsShiftC         = 8;
   localparam int unsigned SeedWordsPerLane = 4;

   // New w of an xorshift128 step; x, y, z simply shift down one slot.
   function automatic logic [31:0] xs_next_w(input logic [31:0] x, input logic [31:0] w);
      logic [31:0] t;
      t = x ^ (x << XsShiftA);
      return w ^ (w >> XsShiftB) ^ t ^ (t >> XsShiftC);
   endfunction

endpackage

// File: rtl/xorshift128_lane.sv
// One xorshift128 generator lane.
// Ports: clk/rst (async active-low), load + load_idx + load_data write one of
// {x,y,z,w}, step advances the generator, zero_fix forces w=1 if the state
// after this cycle's update would be all-zero, w is the current output word.
module xorshift128_lane
   import mskaes_rnd_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [1:0]  load_idx,
   input  logic [31:0] load_data,
   input  logic        step,
   input  logic        zero_fix,
   output logic [31:0] w
);

   logic [31:0] x_q, y_q, z_q, w_q;
   logic [31:0] x_d, y_d, z_d, w_d;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      z_d = z_q;
      w_d = w_q;
      if (load) begin
         case (load_idx)
            2'd0: x_d = load_data;
            2'd1: y_d = load_data;
            2'd2: z_d = load_data;
            2'd3: w_d = load_data;
            default: ;
         endcase
      end else if (step) begin
         x_d = y_q;
         y_d = z_q;
         z_d = w_q;
         w_d = xs_next_w(x_q, w_q);
      end
      // Checked against the post-load value so the final seed word is included.
      if (zero_fix && (x_d == '0) && (y_d == '0) && (z_d == '0) && (w_d == '0)) begin
         w_d = 32'h1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q <= '0;
         y_q <= '0;
         z_q <= '0;
         w_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
         z_q <= z_d;
         w_q <= w_d;
      end
   end

   assign w = w_q;

endmodule

// File: rtl/mskaes_rnd_feeder.sv
// Randomness responder for the masked AES core.
// Ports: clk/rst (async active-low); seed_data/seed_valid/seed_ready seed
// stream; reseed forces a return to seeding; rnd_need is the core's
// one-cycle-ahead request; rnd_out is RND_WORDS lane words (lane k in bits
// [32k+31:32k]); rnd_valid marks READY; reseed_req marks the exhausted stall.
module mskaes_rnd_feeder
   import mskaes_rnd_pkg::*;
#(
   parameter int unsigned RND_WORDS    = 4,
   parameter int unsigned WARMUP       = 16,
   parameter int unsigned RESEED_LIMIT = 2**20
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            seed_data,
   input  logic                   seed_valid,
   output logic                   seed_ready,
   input  logic                   reseed,
   input  logic                   rnd_need,
   output logic [32*RND_WORDS-1:0] rnd_out,
   output logic                   rnd_valid,
   output logic                   reseed_req
);

   localparam int unsigned SeedWords = SeedWordsPerLane * RND_WORDS;
   localparam int unsigned IdxW      = $clog2(SeedWords + 1);
   localparam int unsigned WarmW     = $clog2(WARMUP + 2);
   localparam int unsigned CntW      = $clog2(RESEED_LIMIT + 1);

   rnd_state_e       state_q, state_d;
   logic [IdxW-1:0]  seed_idx_q;
   logic [WarmW-1:0] warm_cnt_q;
   logic [CntW-1:0]  step_cnt_q;

   logic accept, last_word, warm_done, ready_step, step_en;

   // A seed word arriving with reseed is dropped: the index restarts instead.
   assign accept     = seed_valid && seed_ready && !reseed;
   assign last_word  = accept && (seed_idx_q == IdxW'(SeedWords - 1));
   assign warm_done  = (warm_cnt_q == WarmW'(WARMUP - 1));
   assign ready_step = (state_q == StReady) && rnd_need && !reseed;
   assign step_en    = ready_step || ((state_q == StWarm) && !reseed);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StSeed: begin
            if (last_word) state_d = (WARMUP == 0) ? StReady : StWarm;
         end
         StWarm: begin
            if (reseed)         state_d = StSeed;
            else if (warm_done) state_d = StReady;
         end
         StReady: begin
            if (reseed) begin
               state_d = StSeed;
            end else if (rnd_need && (step_cnt_q == CntW'(RESEED_LIMIT - 1))) begin
               state_d = StExhausted;
            end
         end
         StExhausted: begin
            if (reseed) state_d = StSeed;
         end
         default: state_d = StSeed;
      endcase
   end

   // Outputs are registered from the next state so they change with state_q.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StSeed;
         seed_idx_q <= '0;
         warm_cnt_q <= '0;
         step_cnt_q <= '0;
         seed_ready <= 1'b1;
         rnd_valid  <= 1'b0;
         reseed_req <= 1'b0;
      end else begin
         state_q    <= state_d;
         seed_ready <= (state_d == StSeed);
         rnd_valid  <= (state_d == StReady);
         reseed_req <= (state_d == StExhausted);
         if (reseed) begin
            seed_idx_q <= '0;
            warm_cnt_q <= '0;
            step_cnt_q <= '0;
         end else begin
            if (accept) seed_idx_q <= last_word ? '0 : seed_idx_q + 1'b1;
            if (state_q == StWarm) warm_cnt_q <= warm_done ? '0 : warm_cnt_q + 1'b1;
            // Never counts past RESEED_LIMIT: the last step leaves READY.
            if (ready_step) step_cnt_q <= step_cnt_q + 1'b1;
         end
      end
   end

   for (genvar k = 0; k < RND_WORDS; k++) begin : g_lane
      logic lane_load;
      assign lane_load = accept && ((seed_idx_q >> 2) == IdxW'(k));

      xorshift128_lane u_lane (
         .clk       (clk),
         .rst       (rst),
         .load      (lane_load),
         .load_idx  (seed_idx_q[1:0]),
         .load_data (seed_data),
         .step      (step_en),
         .zero_fix  (last_word),
         .w         (rnd_out[32*k +: 32])
      );
   end

endmodule

// File: tb/tb_mskaes_rnd_feeder.sv
// Directed bench: dut_a (1 lane, no warm-up, limit 8) and dut_b (2 lanes,
// 16 warm-up steps) share clock and reset but have separate stimulus.
module tb_mskaes_rnd_feeder;

   logic        clk = 1'b0;
   logic        rst;

   logic [31:0] a_seed_data, b_seed_data;
   logic        a_seed_valid, b_seed_valid;
   logic        a_seed_ready, b_seed_ready;
   logic        a_reseed, b_reseed;
   logic        a_rnd_need, b_rnd_need;
   logic [31:0] a_rnd_out;
   logic [63:0] b_rnd_out;
   logic        a_rnd_valid, b_rnd_valid;
   logic        a_reseed_req, b_reseed_req;

   int n_vec = 0;
   int n_err = 0;

   logic [127:0] ma, mb0, mb1;
   int           cyc;

   always #5 clk = ~clk;

   mskaes_rnd_feeder #(
      .RND_WORDS    (1),
      .WARMUP       (0),
      .RESEED_LIMIT (8)
   ) dut_a (
      .clk        (clk),
      .rst        (rst),
      .seed_data  (a_seed_data),
      .seed_valid (a_seed_valid),
      .seed_ready (a_seed_ready),
      .reseed     (a_reseed),
      .rnd_need   (a_rnd_need),
      .rnd_out    (a_rnd_out),
      .rnd_valid  (a_rnd_valid),
      .reseed_req (a_reseed_req)
   );

   mskaes_rnd_feeder #(
      .RND_WORDS    (2),
      .WARMUP       (16),
      .RESEED_LIMIT (2**20)
   ) dut_b (
      .clk        (clk),
      .rst        (rst),
      .seed_data  (b_seed_data),
      .seed_valid (b_seed_valid),
      .seed_ready (b_seed_ready),
      .reseed     (b_reseed),
      .rnd_need   (b_rnd_need),
      .rnd_out    (b_rnd_out),
      .rnd_valid  (b_rnd_valid),
      .reseed_req (b_reseed_req)
   );

   // Reference xorshift128 step on a {x,y,z,w} state.
   function automatic logic [127:0] xs_step(input logic [127:0] s);
      logic [31:0] x, y, z, w, t;
      x = s[127:96];
      y = s[95:64];
      z = s[63:32];
      w = s[31:0];
      t = x ^ (x << 11);
      return {y, z, w, w ^ (w >> 19) ^ t ^ (t >> 8)};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic a_seed4(input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
      logic [31:0] ws [4];
      ws = '{w0, w1, w2, w3};
      for (int i = 0; i < 4; i++) begin
         a_seed_valid = 1'b1;
         a_seed_data  = ws[i];
         @(negedge clk);
      end
      a_seed_valid = 1'b0;
   endtask

   task automatic b_seed8(input logic [31:0] ws [8]);
      for (int i = 0; i < 8; i++) begin
         b_seed_valid = 1'b1;
         b_seed_data  = ws[i];
         @(negedge clk);
      end
      b_seed_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] bw [8];
      rst = 1'b0;
      a_seed_data = '0; a_seed_valid = 1'b0; a_reseed = 1'b0; a_rnd_need = 1'b0;
      b_seed_data = '0; b_seed_valid = 1'b0; b_reseed = 1'b0; b_rnd_need = 1'b0;
      repeat (2) @(negedge clk);

      check("rst_a_seed_ready", a_seed_ready, 1);
      check("rst_a_rnd_valid",  a_rnd_valid,  0);
      check("rst_a_reseed_req", a_reseed_req, 0);
      check("rst_a_rnd_out",    a_rnd_out,    0);
      check("rst_b_seed_ready", b_seed_ready, 1);
      check("rst_b_rnd_out",    b_rnd_out,    0);

      rst = 1'b1;
      @(negedge clk);

      // Seed 1,2,3,4 and take one step.
      a_seed4(32'd1, 32'd2, 32'd3, 32'd4);
      check("a_valid_after_load", a_rnd_valid,  1);
      check("a_ready_dropped",    a_seed_ready, 0);
      check("a_out_seed_w",       a_rnd_out,    32'h4);
      a_rnd_need = 1'b1;
      @(negedge clk);
      a_rnd_need = 1'b0;
      check("a_out_step1", a_rnd_out, 32'h80D);
      @(negedge clk);
      check("a_out_hold", a_rnd_out, 32'h80D);

      // reseed together with need: reseed wins, no step.
      a_reseed = 1'b1; a_rnd_need = 1'b1;
      @(negedge clk);
      a_reseed = 1'b0; a_rnd_need = 1'b0;
      check("a_reseed_seed_ready", a_seed_ready, 1);
      check("a_reseed_valid",      a_rnd_valid,  0);
      check("a_reseed_nostep",     a_rnd_out,    32'h80D);

      // All-zero seed gets w forced to 1.
      a_seed4(32'd0, 32'd0, 32'd0, 32'd0);
      check("a_zero_valid", a_rnd_valid, 1);
      check("a_zero_guard", a_rnd_out,   32'h1);
      a_rnd_need = 1'b1;
      @(negedge clk);
      a_rnd_need = 1'b0;
      check("a_zero_step", a_rnd_out, 32'h1);

      // Exhaustion after 8 served steps.
      a_reseed = 1'b1;
      @(negedge clk);
      a_reseed = 1'b0;
      a_seed4(32'd1, 32'd2, 32'd3, 32'd4);
      ma = {32'd1, 32'd2, 32'd3, 32'd4};
      a_rnd_need = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i <= 8) ma = xs_step(ma);
         check($sformatf("a_exh_out_%0d", i),   a_rnd_out,    ma[31:0]);
         check($sformatf("a_exh_valid_%0d", i), a_rnd_valid,  (i < 8) ? 1 : 0);
         check($sformatf("a_exh_req_%0d", i),   a_reseed_req, (i >= 8) ? 1 : 0);
      end
      a_rnd_need = 1'b0;

      a_reseed = 1'b1;
      @(negedge clk);
      a_reseed = 1'b0;
      check("a_exh_reseed_req",   a_reseed_req, 0);
      check("a_exh_reseed_ready", a_seed_ready, 1);

      // Reset mid-seed, then the next stream must start at index 0.
      a_seed_valid = 1'b1; a_seed_data = 32'd5;
      @(negedge clk);
      a_seed_data = 32'd6;
      @(negedge clk);
      a_seed_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("a_midseed_rst_ready", a_seed_ready, 1);
      check("a_midseed_rst_out",   a_rnd_out,    0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      a_seed4(32'd7, 32'd8, 32'd9, 32'd10);
      ma = {32'd7, 32'd8, 32'd9, 32'd10};
      check("a_reload_valid", a_rnd_valid, 1);
      check("a_reload_out",   a_rnd_out,   32'd10);
      a_rnd_need = 1'b1;
      @(negedge clk);
      a_rnd_need = 1'b0;
      ma = xs_step(ma);
      check("a_reload_step", a_rnd_out, ma[31:0]);

      // Reset in READY.
      rst = 1'b0;
      #1;
      check("a_ready_rst_valid", a_rnd_valid,  0);
      check("a_ready_rst_out",   a_rnd_out,    0);
      check("a_ready_rst_sready", a_seed_ready, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // dut_b: reseed in SEED restarts the index and drops that cycle's word.
      for (int i = 0; i < 3; i++) begin
         b_seed_valid = 1'b1;
         b_seed_data  = 32'hAAAA_0000 + 32'(i);
         @(negedge clk);
      end
      b_reseed = 1'b1; b_seed_data = 32'hDEAD_BEEF;
      @(negedge clk);
      b_reseed = 1'b0; b_seed_valid = 1'b0;

      bw = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0};
      b_seed8(bw);
      cyc = 1;
      while (!b_rnd_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("b_warm_latency", 64'(cyc), 64'd17);

      mb0 = {32'd1, 32'd2, 32'd3, 32'd4};
      mb1 = {32'd0, 32'd0, 32'd0, 32'd1};
      for (int i = 0; i < 16; i++) begin
         mb0 = xs_step(mb0);
         mb1 = xs_step(mb1);
      end
      check("b_post_warm", b_rnd_out, {mb1[31:0], mb0[31:0]});

      b_rnd_need = 1'b1;
      @(negedge clk);
      b_rnd_need = 1'b0;
      mb0 = xs_step(mb0); mb1 = xs_step(mb1);
      check("b_step1", b_rnd_out, {mb1[31:0], mb0[31:0]});
      @(negedge clk);
      check("b_hold", b_rnd_out, {mb1[31:0], mb0[31:0]});
      b_rnd_need = 1'b1;
      @(negedge clk);
      b_rnd_need = 1'b0;
      mb0 = xs_step(mb0); mb1 = xs_step(mb1);
      check("b_step2", b_rnd_out, {mb1[31:0], mb0[31:0]});
      check("b_valid", b_rnd_valid, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mskaes_rnd_feeder.md
Name: mskaes_rnd_feeder

Overview:
- Randomness responder for the masked AES core's randomness request (`in_ready_rnd`, a one-cycle-ahead "need" strobe).
- Holds RND_WORDS independent xorshift128 instances; each instance produces one 32-bit word per step.
- Seeded through a 32-bit valid/ready stream, then runs a warm-up.
- Delivers a fresh RND_WORDS*32-bit word on every cycle following an asserted need. Sits between the top-level seed interface and the core's `rnd_bus*w` inputs.

Parameters:
- RND_WORDS, 4, number of 32-bit xorshift128 instances (output width 32*RND_WORDS).
- WARMUP, 16, discarded steps after seeding (0 allowed).
- RESEED_LIMIT, 2**20, served steps before a reseed is mandatory.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- seed_data  in  32  seed word.
- seed_valid  in  1  seed word present.
- seed_ready  out  1  feeder accepts seed words (SEED state).
- reseed  in  1  request entry to SEED state (level, sampled each cycle).
- rnd_need  in  1  driven by the core's `in_ready_rnd`; randomness is consumed next cycle.
- rnd_out  out  32*RND_WORDS  randomness word; word k = instance k's w register.
- rnd_valid  out  1  feeder is READY, so `rnd_out` is fresh whenever the core consumes it.
- reseed_req  out  1  RESEED_LIMIT reached; feeder stalled until reseeded.

Behaviour:
- Reset (rst=0, async): state=SEED, all instance registers 0, seed/step/warm-up counters 0.
  - Outputs: seed_ready=1, rnd_valid=0, reseed_req=0, rnd_out=0.
- States: SEED -> WARM -> READY -> (EXHAUSTED | SEED).
- SEED:
  - A seed word is accepted on a cycle with seed_valid&seed_ready.
  - 4*RND_WORDS words are loaded in order: instance 0 {x,y,z,w}, then instance 1, and so on.
  - After the last word: seed_ready drops the next cycle. If WARMUP=0, go to READY; else go to WARM.
  - Zero guard: at load completion, any instance with x=y=z=w=0 has its w forced to 32'h1.
- WARM:
  - Every instance steps once per cycle for WARMUP cycles, unconditionally.
  - Then go to READY. rnd_valid=0 throughout WARM.
- READY:
  - rnd_valid=1.
  - On a cycle with rnd_need=1, all instances step at that clock edge, so `rnd_out` is new in the following cycle.
  - On a cycle with rnd_need=0, state is held and `rnd_out` is stable.
  - Each step increments the step counter.
  - When the counter reaches RESEED_LIMIT, go to EXHAUSTED.
- EXHAUSTED:
  - rnd_valid=0, reseed_req=1, `rnd_out` held.
  - rnd_need is ignored; no steps occur.
- Step function, per instance, 32-bit arithmetic with shifts zero-filling:
  - t = x ^ (x<<11)
  - x' = y, y' = z, z' = w
  - w' = w ^ (w>>19) ^ t ^ (t>>8)
- reseed=1 in WARM, READY or EXHAUSTED:
  - Next state is SEED. Seed index, step counter and warm-up counter cleared; reseed_req=0; rnd_valid=0 from the next cycle.
  - Instance registers are overwritten only as new seed words arrive.
  - reseed in SEED restarts the seed index at 0. An accept on that same cycle is dropped.
- Simultaneous reseed and rnd_need in READY: reseed wins and no step occurs.
- An incomplete seed stream holds SEED indefinitely.
- rnd_need is ignored outside READY.
- Counter boundary: the step counter saturates at RESEED_LIMIT and never wraps.
- The core must only start when rnd_valid=1. This is a system-level integration rule, not checked by this block.

Decomposition:
- Shared package `mskaes_rnd_pkg`:
  - State encoding constants (SEED, WARM, READY, EXHAUSTED).
  - Xorshift shift amounts 11/19/8.
  - Seed-words-per-instance constant 4.
- Sub-module `xorshift128_lane`: one instance, with inputs load, load_idx[1:0], load_data, step, zero_fix, and output w.
- The top contains the FSM, counters, seed index and a generate loop over RND_WORDS.

Test Plan:
- RND_WORDS=1, WARMUP=0. Reset, seed 1,2,3,4, then hold rnd_need=1 for 1 cycle.
  - rnd_valid=1 after load; rnd_out=0x00000004 before the step and 0x0000080D the cycle after.
- RND_WORDS=1, WARMUP=0. Seed 0,0,0,0.
  - rnd_out=0x00000001 (zero guard); the first step yields 0x00000001 (t=0, w>>19=0).
- WARMUP=16. Count cycles from the last seed accept to rnd_valid=1: must be exactly 17.
  - With 16 steps pre-applied in the reference model, outputs match the model thereafter.
- RESEED_LIMIT=8. Hold rnd_need=1 for 10 cycles.
  - Exactly 8 distinct words are served; reseed_req=1 and rnd_valid=0 from the 9th cycle; rnd_out is frozen.
- In READY, pulse reseed together with rnd_need.
  - No step occurs; seed_ready=1 next cycle; a new 4-word seed yields model-matching outputs.
- Assert rst low mid-seed (after 2 words) and mid-READY.
  - Outputs immediately take reset values; the next seed stream is loaded from index 0.
